// File: rtl/sprite_arb_pkg.sv
// Shared constants and types for the sprite ROM arbiter.
// The arbiter and its picker both import this package.
package sprite_arb_pkg;

    localparam int SPRITE_N_REQ  = 4;
    localparam int SPRITE_ADDR_W = 16;
    localparam int SPRITE_DATA_W = 4;

    // Internal slot ids are sized for the largest supported requester count (8).
    localparam int SPRITE_ID_W = 3;

    typedef logic [$clog2(SPRITE_N_REQ)-1:0] req_id_t;
    typedef logic [SPRITE_ID_W-1:0]          slot_id_t;

    typedef struct packed {
        logic     valid;
        slot_id_t id;
    } ret_stage_t;

endpackage

// File: rtl/sprite_rr_pick.sv
// Combinational round-robin picker: the first eligible index at or after
// start, wrapping around, is returned as a one-hot winner with a found flag.
module sprite_rr_pick
    import sprite_arb_pkg::*;
#(
    parameter int N = SPRITE_N_REQ
) (
    input  logic [N-1:0] eligible,
    input  slot_id_t     start,
    output logic [N-1:0] winner,
    output logic         found
);

    always_comb begin
        // NOTE: every output gets a default before the search, otherwise an
        // empty eligible mask would leave them unassigned and infer latches.
        winner = '0;
        found  = 1'b0;
        // First pass covers [start, N-1]; the second covers the wrap [0, start-1].
        for (int i = 0; i < N; i++) begin
            if (!found && eligible[i] && i >= int'(start)) begin
                winner[i] = 1'b1;
                found     = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && eligible[i] && i < int'(start)) begin
                winner[i] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one sprite ROM read port among N_REQ requesters.
// Define SPRITE_ARB_PRIO0_EN to give requester 0 absolute priority.
module sprite_rom_arbiter
    import sprite_arb_pkg::*;
#(
    parameter int N_REQ   = SPRITE_N_REQ,
    parameter int ADDR_W  = SPRITE_ADDR_W,
    parameter int DATA_W  = SPRITE_DATA_W,
    parameter int ROM_LAT = 1
) (
    input  logic                    vga_clk,
    input  logic                    reset_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*ADDR_W-1:0] addr,
    output logic [N_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]       rom_address,
    input  logic [DATA_W-1:0]       rom_q,
    output logic [N_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]       rdata
);

    slot_id_t           last;
    slot_id_t           start;
    slot_id_t           win_id;
    logic [N_REQ-1:0]   eligible;
    logic [N_REQ-1:0]   rr_eligible;
    logic [N_REQ-1:0]   rr_winner;
    logic               rr_found;
    logic [N_REQ-1:0]   winner;
    logic               found;
    logic               last_update;
    logic [ADDR_W-1:0]  win_addr;
    logic [N_REQ-1:0]   ret_hit;
    ret_stage_t         pipe [ROM_LAT];

    // The requester holding the grant this cycle sits out the next arbitration.
    assign eligible = req & ~gnt;
    assign start    = (last == slot_id_t'(N_REQ-1)) ? '0 : last + slot_id_t'(1);

`ifdef SPRITE_ARB_PRIO0_EN
    assign rr_eligible = eligible & {{(N_REQ-1){1'b1}}, 1'b0};
    assign winner      = eligible[0] ? {{(N_REQ-1){1'b0}}, 1'b1} : rr_winner;
    assign found       = eligible[0] | rr_found;
    assign last_update = rr_found & ~eligible[0];
`else
    assign rr_eligible = eligible;
    assign winner      = rr_winner;
    assign found       = rr_found;
    assign last_update = rr_found;
`endif

    sprite_rr_pick #(.N(N_REQ)) u_pick (
        .eligible (rr_eligible),
        .start    (start),
        .winner   (rr_winner),
        .found    (rr_found)
    );

    always_comb begin
        win_id   = '0;
        win_addr = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (winner[i]) begin
                win_id   = slot_id_t'(i);
                win_addr = addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_comb begin
        ret_hit = '0;
        for (int i = 0; i < N_REQ; i++) begin
            ret_hit[i] = pipe[ROM_LAT-1].valid && (pipe[ROM_LAT-1].id == slot_id_t'(i));
        end
    end

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            gnt         <= '0;
            rom_address <= '0;
            last        <= slot_id_t'(N_REQ-1);
            rvalid      <= '0;
            rdata       <= '0;
            for (int k = 0; k < ROM_LAT; k++) begin
                pipe[k] <= '{valid: 1'b0, id: '0};
            end
        end else begin
            // NOTE: non-blocking updates so every register sees pre-edge values,
            // which lets the pipeline shift and the grant feed back cleanly.
            gnt <= winner;
            if (found) begin
                rom_address <= win_addr;
            end
            if (last_update) begin
                last <= win_id;
            end
            pipe[0] <= '{valid: found, id: win_id};
            for (int k = 1; k < ROM_LAT; k++) begin
                pipe[k] <= pipe[k-1];
            end
            rvalid <= ret_hit;
            if (pipe[ROM_LAT-1].valid) begin
                rdata <= rom_q;
            end
        end
    end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Self-checking bench: a ROM_LAT=1 instance driven from a vector table and a
// ROM_LAT=2 instance for latency and reset-while-in-flight sequences.
module tb_sprite_rom_arbiter;
    import sprite_arb_pkg::*;

    localparam logic [15:0] A0 = 16'h00A5;
    localparam logic [15:0] A1 = 16'h0B76;
    localparam logic [15:0] A2 = 16'h1234;
    localparam logic [15:0] A3 = 16'hC0D9;

    logic        vga_clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req;
    logic [63:0] addr;

    logic [3:0]  gnt1, rvalid1, rdata1, rom_q1;
    logic [15:0] rom_address1;
    logic [3:0]  gnt2, rvalid2, rdata2, rom_q2;
    logic [15:0] rom_address2;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic        rst_n;
        logic [3:0]  req;
        logic [3:0]  gnt;
        logic [15:0] rom_address;
        logic [3:0]  rvalid;
        logic [3:0]  rdata;
    } vec_t;

    vec_t vecs[$];

    always #5 vga_clk = ~vga_clk;

    sprite_rom_arbiter #(.N_REQ(4), .ADDR_W(16), .DATA_W(4), .ROM_LAT(1)) dut1 (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .req         (req),
        .addr        (addr),
        .gnt         (gnt1),
        .rom_address (rom_address1),
        .rom_q       (rom_q1),
        .rvalid      (rvalid1),
        .rdata       (rdata1)
    );

    sprite_rom_arbiter #(.N_REQ(4), .ADDR_W(16), .DATA_W(4), .ROM_LAT(2)) dut2 (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .req         (req),
        .addr        (addr),
        .gnt         (gnt2),
        .rom_address (rom_address2),
        .rom_q       (rom_q2),
        .rvalid      (rvalid2),
        .rdata       (rdata2)
    );

    // ROM models return the low nibble of the address; latency 1 is
    // combinational from the registered address, latency 2 adds one register.
    assign rom_q1 = rom_address1[3:0];
    always @(posedge vga_clk) rom_q2 <= rom_address2[3:0];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] q, input logic [3:0] g,
                       input logic [15:0] ra, input logic [3:0] rv, input logic [3:0] rd);
        vec_t v;
        v.rst_n = r; v.req = q; v.gnt = g; v.rom_address = ra; v.rvalid = rv; v.rdata = rd;
        vecs.push_back(v);
    endtask

    task automatic step(input logic r, input logic [3:0] q);
        reset_n = r;
        req     = q;
        @(posedge vga_clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        req     = '0;
        addr    = {A3, A2, A1, A0};

        // Reset with all requesters active, then back-to-back grants.
        add(0, 4'b1111, 4'b0000, 16'h0000, 4'b0000, 4'h0);
        add(0, 4'b1111, 4'b0000, 16'h0000, 4'b0000, 4'h0);
`ifdef SPRITE_ARB_PRIO0_EN
        add(1, 4'b1111, 4'b0001, A0, 4'b0000, 4'h0);
        add(1, 4'b1111, 4'b0010, A1, 4'b0001, 4'h5);
        add(1, 4'b1111, 4'b0001, A0, 4'b0010, 4'h6);
        add(1, 4'b1111, 4'b0100, A2, 4'b0001, 4'h5);
        add(1, 4'b1111, 4'b0001, A0, 4'b0100, 4'h4);
        add(1, 4'b1111, 4'b1000, A3, 4'b0001, 4'h5);
        add(1, 4'b1111, 4'b0001, A0, 4'b1000, 4'h9);
        add(1, 4'b1111, 4'b0010, A1, 4'b0001, 4'h5);
        add(1, 4'b0000, 4'b0000, A1, 4'b0010, 4'h6);
`else
        add(1, 4'b1111, 4'b0001, A0, 4'b0000, 4'h0);
        add(1, 4'b1111, 4'b0010, A1, 4'b0001, 4'h5);
        add(1, 4'b1111, 4'b0100, A2, 4'b0010, 4'h6);
        add(1, 4'b1111, 4'b1000, A3, 4'b0100, 4'h4);
        add(1, 4'b1111, 4'b0001, A0, 4'b1000, 4'h9);
        add(1, 4'b1111, 4'b0010, A1, 4'b0001, 4'h5);
        add(1, 4'b1111, 4'b0100, A2, 4'b0010, 4'h6);
        add(1, 4'b1111, 4'b1000, A3, 4'b0100, 4'h4);
        add(1, 4'b0000, 4'b0000, A3, 4'b1000, 4'h9);
`endif
        add(0, 4'b0000, 4'b0000, 16'h0000, 4'b0000, 4'h0);
        // Single requester 2 holding req: grant on alternate cycles.
        add(1, 4'b0100, 4'b0100, A2, 4'b0000, 4'h0);
        add(1, 4'b0100, 4'b0000, A2, 4'b0100, 4'h4);
        add(1, 4'b0100, 4'b0100, A2, 4'b0000, 4'h4);
        add(1, 4'b0100, 4'b0000, A2, 4'b0100, 4'h4);
        // Grant to 2, then 1 and 3 together: 3 first, then 1.
        add(1, 4'b0100, 4'b0100, A2, 4'b0000, 4'h4);
        add(1, 4'b1010, 4'b1000, A3, 4'b0100, 4'h4);
        add(1, 4'b0010, 4'b0010, A1, 4'b1000, 4'h9);
        add(1, 4'b0000, 4'b0000, A1, 4'b0010, 4'h6);
        // req[1] pulsed for one cycle while requester 0 wins: no trace of 1.
        add(1, 4'b0011, 4'b0001, A0, 4'b0000, 4'h6);
        add(1, 4'b0000, 4'b0000, A0, 4'b0001, 4'h5);
        add(1, 4'b0000, 4'b0000, A0, 4'b0000, 4'h5);

        foreach (vecs[i]) begin
            step(vecs[i].rst_n, vecs[i].req);
            check($sformatf("v%0d gnt", i),         32'(gnt1),         32'(vecs[i].gnt));
            check($sformatf("v%0d rom_address", i), 32'(rom_address1), 32'(vecs[i].rom_address));
            check($sformatf("v%0d rvalid", i),      32'(rvalid1),      32'(vecs[i].rvalid));
            check($sformatf("v%0d rdata", i),       32'(rdata1),       32'(vecs[i].rdata));
        end

        // ROM_LAT=2: end-to-end latency is three posedges.
        step(0, 4'b0000);
        step(1, 4'b0100);
        check("lat2 gnt",          32'(gnt2),         32'(4'b0100));
        check("lat2 rom_address",  32'(rom_address2), 32'(A2));
        check("lat2 early rvalid", 32'(rvalid2),      32'(4'b0000));
        step(1, 4'b0000);
        check("lat2 mid rvalid",   32'(rvalid2),      32'(4'b0000));
        step(1, 4'b0000);
        check("lat2 rvalid",       32'(rvalid2),      32'(4'b0100));
        check("lat2 rdata",        32'(rdata2),       32'(4'h4));

        // ROM_LAT=2: reset one cycle after a grant drops the in-flight read.
        step(1, 4'b0001);
        check("flush gnt",         32'(gnt2),         32'(4'b0001));
        check("flush rom_address", 32'(rom_address2), 32'(A0));
        step(0, 4'b0000);
        check("flush rst gnt",     32'(gnt2),         32'(4'b0000));
        check("flush rst rvalid",  32'(rvalid2),      32'(4'b0000));
        check("flush rst addr",    32'(rom_address2), 32'(16'h0000));
        check("flush rst rdata",   32'(rdata2),       32'(4'h0));
        for (int c = 0; c < 4; c++) begin
            step(1, 4'b0000);
            check($sformatf("flush c%0d rvalid", c), 32'(rvalid2), 32'(4'b0000));
            check($sformatf("flush c%0d rdata", c),  32'(rdata2),  32'(4'h0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
